// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : reset_sequencer_pkg
// Brief  : State encoding and default timing constants for the reset sequencer
// Rev    : 1.0
// ============================================================================
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    REL_PSRAM  = 3'd1,
    RETRY_HOLD = 3'd2,
    GAP_VIC    = 3'd3,
    GAP_HDMI   = 3'd4,
    RUN        = 3'd5,
    FAULT      = 3'd6
  } seq_state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP          = 16;
  localparam int DEF_PSRAM_TIMEOUT      = 65536;
  localparam int DEF_MAX_RETRIES        = 3;
  localparam int DEF_SYNC_STAGES        = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_sync_bit.sv
`default_nettype none
// ============================================================================
// Module : sync_bit
// Brief  : Multi-flop single-bit synchroniser with asynchronous clear
// Rev    : 1.0
// ============================================================================
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= (r_chain << 1) | STAGES'(d);
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module : reset_sequencer
// Brief  : Ordered PSRAM -> VIC -> HDMI reset release gated on PLL lock
// Rev    : 1.0
// ============================================================================
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_GAP          = DEF_STAGE_GAP,
  parameter int PSRAM_TIMEOUT      = DEF_PSRAM_TIMEOUT,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
  input  logic       clk32,
  input  logic       resetn,
  input  logic       lock_5x,
  input  logic       lock_64,
  input  logic       psram_init_done,
  output logic       psram_resetn,
  output logic       vic_resetn,
  output logic       hdmi_resetn,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count
);

  localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, STAGE_GAP, PSRAM_TIMEOUT);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] LOAD_LOCK = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_GAP  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] LOAD_TMO  = CNT_W'(PSRAM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       RETRY_LIM = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

  logic             w_lock_5x_s;
  logic             w_lock_64_s;
  logic             w_init_s;
  logic             w_lock_s;
  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_retry;
  logic [1:0]       w_retry_nxt;
  logic [1:0]       w_retry_inc;
  logic             w_psram;
  logic             w_vic;
  logic             w_hdmi;
  logic             w_ready;
  logic             w_fault;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock_5x (
    .clk(clk32), .rst_n(resetn), .d(lock_5x), .q(w_lock_5x_s)
  );
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock_64 (
    .clk(clk32), .rst_n(resetn), .d(lock_64), .q(w_lock_64_s)
  );
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_init (
    .clk(clk32), .rst_n(resetn), .d(psram_init_done), .q(w_init_s)
  );

  assign w_lock_s    = w_lock_5x_s & w_lock_64_s;
  assign w_retry_inc = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;

  always_ff @(posedge clk32 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_retry      <= 2'd0;
      psram_resetn <= 1'b0;
      vic_resetn   <= 1'b0;
      hdmi_resetn  <= 1'b0;
      ready        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      psram_resetn <= w_psram;
      vic_resetn   <= w_vic;
      hdmi_resetn  <= w_hdmi;
      ready        <= w_ready;
      fault        <= w_fault;
    end
  end

  // The shared counter is reloaded on every state entry and counts down to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    if (r_state != WAIT_LOCK && r_state != FAULT && !w_lock_s) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = LOAD_LOCK;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (!w_lock_s) begin
            w_cnt_nxt = LOAD_LOCK;
          end else if (r_cnt == '0) begin
            w_state_nxt = REL_PSRAM;
            w_cnt_nxt   = LOAD_TMO;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        REL_PSRAM: begin
          if (w_init_s) begin
            w_state_nxt = GAP_VIC;
            w_cnt_nxt   = LOAD_GAP;
          end else if (r_cnt == '0) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == RETRY_LIM) ? FAULT : RETRY_HOLD;
            w_cnt_nxt   = LOAD_GAP;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        RETRY_HOLD: begin
          if (r_cnt == '0) begin
            w_state_nxt = REL_PSRAM;
            w_cnt_nxt   = LOAD_TMO;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        GAP_VIC: begin
          if (r_cnt == '0) begin
            w_state_nxt = GAP_HDMI;
            w_cnt_nxt   = LOAD_GAP;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        GAP_HDMI: begin
          if (r_cnt == '0) begin
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        RUN: begin
          if (!w_init_s) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = LOAD_LOCK;
          end
        end
        FAULT: begin
        end
        default: begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = LOAD_LOCK;
        end
      endcase
    end
  end

  // Outputs decode the next state so they register on the transition edge itself.
  always_comb begin
    w_psram = 1'b0;
    w_vic   = 1'b0;
    w_hdmi  = 1'b0;
    w_ready = 1'b0;
    w_fault = 1'b0;
    case (w_state_nxt)
      REL_PSRAM, GAP_VIC: w_psram = 1'b1;
      GAP_HDMI: begin
        w_psram = 1'b1;
        w_vic   = 1'b1;
      end
      RUN: begin
        w_psram = 1'b1;
        w_vic   = 1'b1;
        w_hdmi  = 1'b1;
        w_ready = 1'b1;
      end
      FAULT:   w_fault = 1'b1;
      default: ;
    endcase
  end

  assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_reset_sequencer
// Brief  : Randomised scoreboard bench for reset_sequencer against a cycle model
// Rev    : 1.0
// ============================================================================
module tb_reset_sequencer;

  localparam int LSC = 8;
  localparam int SG  = 4;
  localparam int PT  = 32;
  localparam int MR  = 3;
  localparam int SS  = 2;

  localparam int PH_LOCK  = 0;
  localparam int PH_TRY   = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_VIC   = 3;
  localparam int PH_HDMI  = 4;
  localparam int PH_RUN   = 5;
  localparam int PH_FAULT = 6;

  logic       clk32 = 1'b0;
  logic       resetn = 1'b0;
  logic       lock_5x = 1'b0;
  logic       lock_64 = 1'b0;
  logic       psram_init_done = 1'b0;
  logic       psram_resetn;
  logic       vic_resetn;
  logic       hdmi_resetn;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(LSC), .STAGE_GAP(SG), .PSRAM_TIMEOUT(PT),
    .MAX_RETRIES(MR), .SYNC_STAGES(SS)
  ) dut (
    .clk32(clk32), .resetn(resetn), .lock_5x(lock_5x), .lock_64(lock_64),
    .psram_init_done(psram_init_done), .psram_resetn(psram_resetn),
    .vic_resetn(vic_resetn), .hdmi_resetn(hdmi_resetn), .ready(ready),
    .fault(fault), .retry_count(retry_count)
  );

  always #5 clk32 = ~clk32;

  // Reference model: phase, cycles spent in it, and how many consumers are released.
  int   ph = PH_LOCK;
  int   el = 0;
  int   rel = 0;
  int   rty = 0;
  bit   flt = 0;
  bit   lk_pipe[SS];
  bit   id_pipe[SS];
  logic [6:0] exp_q[$];

  task automatic model_step(input bit rn, input bit lk, input bit id);
    bit ls;
    bit is;
    if (!rn) begin
      ph = PH_LOCK; el = 0; rel = 0; rty = 0; flt = 0;
      for (int i = 0; i < SS; i++) begin
        lk_pipe[i] = 0;
        id_pipe[i] = 0;
      end
      return;
    end
    ls = lk_pipe[0];
    is = id_pipe[0];
    for (int i = 0; i < SS - 1; i++) begin
      lk_pipe[i] = lk_pipe[i+1];
      id_pipe[i] = id_pipe[i+1];
    end
    lk_pipe[SS-1] = lk;
    id_pipe[SS-1] = id;
    if (ph != PH_LOCK && ph != PH_FAULT && !ls) begin
      ph = PH_LOCK; el = 0; rel = 0;
    end else begin
      case (ph)
        PH_LOCK: begin
          if (!ls) el = 0;
          else if (el == LSC - 1) begin ph = PH_TRY; el = 0; rel = 1; end
          else el++;
        end
        PH_TRY: begin
          if (is) begin ph = PH_VIC; el = 0; end
          else if (el == PT - 1) begin
            rel = 0; rty++; el = 0;
            if (rty == MR) begin ph = PH_FAULT; flt = 1; end
            else ph = PH_HOLD;
          end else el++;
        end
        PH_HOLD: begin
          if (el == SG - 1) begin ph = PH_TRY; el = 0; rel = 1; end
          else el++;
        end
        PH_VIC: begin
          if (el == SG - 1) begin ph = PH_HDMI; el = 0; rel = 2; end
          else el++;
        end
        PH_HDMI: begin
          if (el == SG - 1) begin ph = PH_RUN; el = 0; rel = 3; end
          else el++;
        end
        PH_RUN: begin
          if (!is) begin ph = PH_LOCK; el = 0; rel = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [6:0] exp_vec();
    return {rel >= 1, rel >= 2, rel >= 3, ph == PH_RUN, flt, 2'(rty)};
  endfunction

  task automatic drive(input logic rn, input logic l5, input logic l64, input logic id);
    resetn = rn;
    lock_5x = l5;
    lock_64 = l64;
    psram_init_done = id;
    model_step(rn, l5 & l64, id);
    exp_q.push_back(exp_vec());
    @(negedge clk32);
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queued expectation.
  initial begin
    logic [6:0] e;
    logic [6:0] a;
    forever begin
      @(posedge clk32);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {psram_resetn, vic_resetn, hdmi_resetn, ready, fault, retry_count};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs t=%0t got {psram,vic,hdmi,ready,fault,retry}=%b exp %b", $time, a, e);
        end
      end
    end
  end

  task automatic episode(input int ncyc, input int fail_n, input int dly, input int lock_at,
                         input int drop_pm, input int idrop_pm, input int g_at, input int g_len,
                         input bit g_on64, input bit ar_vic);
    int  st_attempt = 0;
    int  st_wait = 0;
    bit  st_prev = 0;
    int  drop_left = 0;
    bit  ar_done = 0;
    bit  l5, l64, id, cur_ps, glitch;
    logic rn;
    logic [6:0] a;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < ncyc; c++) begin
      rn = 1'b1;
      glitch = (c >= g_at) && (c < g_at + g_len);
      if (drop_left > 0) drop_left--;
      else if (drop_pm > 0 && $urandom_range(0, 999) < drop_pm) drop_left = $urandom_range(1, 4);
      l5  = (c >= lock_at) && !(glitch && !g_on64) && (drop_left == 0);
      l64 = (c >= lock_at) && !(glitch && g_on64);
      cur_ps = (rel >= 1);
      if (!cur_ps) id = 0;
      else begin
        if (!st_prev) begin st_attempt++; st_wait = dly; end
        else if (st_wait > 0) st_wait--;
        id = (st_attempt > fail_n) && (st_wait == 0);
      end
      st_prev = cur_ps;
      if (ph == PH_RUN && idrop_pm > 0 && $urandom_range(0, 999) < idrop_pm) id = 0;
      if (ar_vic && !ar_done && ph == PH_VIC) begin
        resetn = 1'b0;
        #1;
        a = {psram_resetn, vic_resetn, hdmi_resetn, ready, fault, retry_count};
        n_checks++;
        if (a !== 7'd0) begin
          n_errors++;
          $display("FAIL async_reset t=%0t got %b exp 0000000", $time, a);
        end
        ar_done = 1;
        rn = 1'b0;
      end
      drive(rn, l5, l64, id);
    end
  endtask

  initial begin
    @(negedge clk32);
    episode(120, 0, 10, 2, 0, 0, -1, 0, 1'b0, 1'b0);   // nominal
    episode(120, 0, 10, 2, 0, 0, 7, 1, 1'b1, 1'b0);    // lock_64 glitch after 5 stable cycles
    episode(200, 99, 10, 2, 0, 0, -1, 0, 1'b0, 1'b0);  // init never completes
    episode(150, 1, 10, 2, 0, 0, -1, 0, 1'b0, 1'b0);   // second attempt succeeds
    episode(200, 0, 10, 2, 0, 0, 90, 3, 1'b0, 1'b0);   // lock_5x loss while running
    episode(150, 1, 10, 2, 0, 0, -1, 0, 1'b0, 1'b1);   // async reset during VIC gap
    for (int r = 0; r < 20; r++) begin
      episode($urandom_range(150, 400), $urandom_range(0, 4), $urandom_range(1, 40),
              $urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 20),
              $urandom_range(0, 300), $urandom_range(1, 3), $urandom_range(0, 1), 1'b0);
    end
    @(posedge clk32);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
